cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

- Fetch/decode/execute controller that sequences the 256×8 single-port program/data `Memory` for the accumulator datapath.
- Holds the program counter, instruction and operand registers, and registers A and B.
- Drives the memory address, write strobe and write data; decodes the 3-bit opcode field.
- Sits between `Memory` and the top level, which only supplies `start` and observes status.

## Interface
Parameters: none; widths are fixed at 8 bits.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins execution from address 0x00 when sampled high in IDLE.
- `mem_rdata`  in  8  `Memory.data_out`; combinational read of `mem_addr`.
- `mem_addr`  out  8  memory address.
- `mem_write`  out  1  memory write strobe, high for exactly one cycle per STR.
- `mem_wdata`  out  8  memory write data.
- `pc`  out  8  program counter.
- `acc_a`  out  8  register A.
- `acc_b`  out  8  register B.
- `carry`  out  1  carry from the last ADD.
- `busy`  out  1  high in FETCH, OPERAND and EXEC.
- `halted`  out  1  high in HALTED.

## Operation
Opcode is `ir[7:5]`; `ir[4:0]` is ignored.
- 010 LDA #imm: two bytes; A <= imm.
- 011 LDB #imm: two bytes; B <= imm.
- 000 ADD: one byte; {carry, A} <= A + B (9-bit sum).
- 100 STR @addr: two bytes; mem[addr] <= A.
- 111 HALT: one byte.
- 001, 101, 110: one-byte NOP; no register change.

State machine, with state encoded in 2–3 flops:
- IDLE: reset state. Moves to FETCH when `start`=1.
- FETCH: `mem_addr`=pc; ir <= mem_rdata; pc <= pc+1.
  - Next is OPERAND for LDA, LDB and STR; otherwise EXEC.
  - The decode uses `mem_rdata` directly.
- OPERAND: `mem_addr`=pc; opr <= mem_rdata; pc <= pc+1. Next is EXEC.
- EXEC: performs the op.
  - STR: `mem_addr`=opr, `mem_wdata`=A, `mem_write`=1.
  - Next is HALTED for HALT; otherwise FETCH.
- HALTED: terminal state. Left only through reset; `start` is ignored.

Outputs are decoded from registered state only: no combinational path from `start` or `mem_rdata` to any output.
- `mem_write`=0 in every state other than EXEC-with-STR.
- `mem_wdata`=A at all times; memory ignores it while `mem_write`=0.
- `mem_addr`=pc in IDLE and HALTED.

Boundary rules:
- pc wraps 0xFF→0x00, including during an operand fetch.
- STR to the address of a later instruction is allowed (self-modifying code); the new byte is fetched.
- `start` is ignored outside IDLE.
- Reset asserted mid-instruction clears everything immediately. `mem_write` drops asynchronously, so a pending store is aborted.

## Timing
- Reset values: state=IDLE, pc=0x00, ir=0x00, opr=0x00, A=0x00, B=0x00, carry=0, `mem_addr`=0x00, `mem_write`=0, `mem_wdata`=0x00, `busy`=0, `halted`=0.
- FETCH is entered on the first edge with `start`=1 in IDLE.
- Cycles per instruction:
  - LDA/LDB: 3 (FETCH, OPERAND, EXEC).
  - STR: 3.
  - ADD/NOP: 2.
  - HALT: 2, then HALTED.
- Register and flag updates are visible on the edge that ends EXEC.
- The memory write occurs during the EXEC cycle; address and data are stable for that whole cycle.

## Configuration
- `CPU_SEQUENCER_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - In FETCH, the controller waits while `step`=0: no ir load, no pc increment, `mem_addr` held at pc.
  - Exactly one instruction executes per cycle in which FETCH sees `step`=1.
- Macro undefined: no `step` port; FETCH always proceeds.

## Test plan
- Demo program (0x40,0x0A,0x60,0x05,0x00,0x80,0x08,0xE0), then `start` pulse:
  - HALTED reached 13 cycles after FETCH entry.
  - mem[8]=0x0F, A=0x0F, B=0x05, carry=0, pc=0x08.
  - `mem_write` high for exactly 1 cycle, with `mem_addr`=0x08.
- LDA #200, LDB #100, ADD, HALT → A=0x2C, carry=1.
- 0x20 (NOP) at 0x00, HALT at 0x01 → A/B unchanged at 0x00, halted after 4 cycles, pc=0x02.
- Memory all 0x20 (NOP) except 0xE0 at 0x01, with LDA at 0xFF and operand 0x33 at 0x00 → after wrap A=0x33, then HALT fetched at 0x01.
- Reset driven low during the STR EXEC cycle → `mem_write` falls without a clock edge, target byte unchanged, all outputs at reset values.
- With `CPU_SEQUENCER_STEP_EN`, `step` held 0 for 10 cycles → pc stays 0x00; one `step` pulse → exactly one LDA completes.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Memory bus between cpu_sequencer (master) and the 256x8 program/data memory (slave).
// Read data is a combinational function of mem_addr; writes happen on the clock edge ending a store.
interface cpu_sequencer_if;
    logic [7:0] mem_addr;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (output mem_addr, output mem_write, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_write, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/operand/execute controller for the 8-bit accumulator machine (LDA, LDB, ADD, STR, HALT, NOP).
// Optional single-step gating of FETCH via `define CPU_SEQUENCER_STEP_EN (adds the step input).
module cpu_sequencer (
    input  logic            clk,
    input  logic            reset,
`ifdef CPU_SEQUENCER_STEP_EN
    input  logic            step,
`endif
    input  logic            start,
    cpu_sequencer_if.master mem,
    output logic [7:0]      pc,
    output logic [7:0]      acc_a,
    output logic [7:0]      acc_b,
    output logic            carry,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_OPERAND = 3'd2,
        S_EXEC    = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b010;
    localparam logic [2:0] OP_LDB  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    // Only the opcode field of the instruction byte affects behaviour, so only it is kept.
    logic [2:0] op_reg, op_next;
    logic [7:0] opr_reg, opr_next;
    logic [7:0] a_reg, a_next;
    logic [7:0] b_reg, b_next;
    logic       carry_reg, carry_next;
    logic [8:0] sum;
    logic       fetch_go;
    logic [2:0] fetched_op;
    logic       store_active;

`ifdef CPU_SEQUENCER_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign sum        = {1'b0, a_reg} + {1'b0, b_reg};
    assign fetched_op = mem.mem_rdata[7:5];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= 8'h00;
            op_reg    <= 3'b000;
            opr_reg   <= 8'h00;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            op_reg    <= op_next;
            opr_reg   <= opr_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        op_next    = op_reg;
        opr_next   = opr_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                // Decode straight off the memory bus so two-byte ops go to OPERAND without a bubble.
                if (fetch_go) begin
                    op_next = fetched_op;
                    pc_next = pc_reg + 8'd1;
                    if (fetched_op == OP_LDA || fetched_op == OP_LDB || fetched_op == OP_STR)
                        state_next = S_OPERAND;
                    else
                        state_next = S_EXEC;
                end
            end
            S_OPERAND: begin
                opr_next   = mem.mem_rdata;
                pc_next    = pc_reg + 8'd1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                case (op_reg)
                    OP_LDA:  a_next = opr_reg;
                    OP_LDB:  b_next = opr_reg;
                    OP_ADD:  {carry_next, a_next} = sum;
                    default: ;
                endcase
                state_next = (op_reg == OP_HALT) ? S_HALTED : S_FETCH;
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_IDLE;
        endcase
    end

    // Bus outputs depend only on registers; the async reset of state_reg kills a pending store at once.
    assign store_active  = (state_reg == S_EXEC) && (op_reg == OP_STR);
    assign mem.mem_write = store_active;
    assign mem.mem_addr  = store_active ? opr_reg : pc_reg;
    assign mem.mem_wdata = a_reg;

    assign pc     = pc_reg;
    assign acc_a  = a_reg;
    assign acc_b  = b_reg;
    assign carry  = carry_reg;
    assign busy   = (state_reg == S_FETCH) || (state_reg == S_OPERAND) || (state_reg == S_EXEC);
    assign halted = (state_reg == S_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: bench-owned memory, scoreboard queues for final state and stores.
// Covers the step-gating test too when built with CPU_SEQUENCER_STEP_EN.
module tb_cpu_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
`ifdef CPU_SEQUENCER_STEP_EN
    logic step  = 1'b1;
`endif
    logic [7:0] pc, acc_a, acc_b;
    logic       carry, busy, halted;
    logic [7:0] mem [0:255];
    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] pc;
        int         cycles;
    } exp_t;
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } store_t;

    exp_t   exp_q[$];
    store_t store_q[$];
    store_t mon_s;

    cpu_sequencer_if bus();

    assign bus.mem_rdata = mem[bus.mem_addr];

    cpu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
`ifdef CPU_SEQUENCER_STEP_EN
        .step   (step),
`endif
        .start  (start),
        .mem    (bus),
        .pc     (pc),
        .acc_a  (acc_a),
        .acc_b  (acc_b),
        .carry  (carry),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
    end

    // Store monitor: every write cycle must match the next expected store.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.mem_write === 1'b1) begin
            compared++;
            if (store_q.size() == 0) begin
                mismatched++;
                $display("FAIL store_unexpected: got write addr=%h data=%h, required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_s = store_q.pop_front();
                if (bus.mem_addr !== mon_s.addr || bus.mem_wdata !== mon_s.data) begin
                    mismatched++;
                    $display("FAIL store_value: got addr=%h data=%h, required addr=%h data=%h", bus.mem_addr, bus.mem_wdata, mon_s.addr, mon_s.data);
                end
            end
        end
    end

    task automatic begin_test(input logic [7:0] fill);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) mem[i] = fill;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_program(output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL fetch_entry: busy=%b required 1", busy); end
        cycles = 0;
        while (halted !== 1'b1 && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        compared++;
        if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, cycles); end
    endtask

    task automatic test_reset();
        begin_test(8'h00);
        #1;
        compared += 6;
        if (pc !== 8'h00)          begin mismatched++; $display("FAIL reset_pc: got %h required 00", pc); end
        if (acc_a !== 8'h00)       begin mismatched++; $display("FAIL reset_a: got %h required 00", acc_a); end
        if (acc_b !== 8'h00)       begin mismatched++; $display("FAIL reset_b: got %h required 00", acc_b); end
        if ({carry, busy, halted} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b required 000", {carry, busy, halted}); end
        if (bus.mem_write !== 1'b0) begin mismatched++; $display("FAIL reset_write: got %b required 0", bus.mem_write); end
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin mismatched++; $display("FAIL reset_bus: got %h required 0000", {bus.mem_addr, bus.mem_wdata}); end
        release_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_without_start: busy=%b required 0", busy); end
    endtask

    task automatic test_demo();
        exp_t e;
        store_t s;
        int cyc;
        begin_test(8'h00);
        mem[0] = 8'h40; mem[1] = 8'h0A; mem[2] = 8'h60; mem[3] = 8'h05;
        mem[4] = 8'h00; mem[5] = 8'h80; mem[6] = 8'h08; mem[7] = 8'hE0;
        e = '{a: 8'h0F, b: 8'h05, c: 1'b0, pc: 8'h08, cycles: 13};
        exp_q.push_back(e);
        s = '{addr: 8'h08, data: 8'h0F};
        store_q.push_back(s);
        release_reset();
        run_program(cyc);
        e = exp_q.pop_front();
        compared += 7;
        if (acc_a !== e.a)   begin mismatched++; $display("FAIL demo_a: got %h required %h", acc_a, e.a); end
        if (acc_b !== e.b)   begin mismatched++; $display("FAIL demo_b: got %h required %h", acc_b, e.b); end
        if (carry !== e.c)   begin mismatched++; $display("FAIL demo_carry: got %b required %b", carry, e.c); end
        if (pc !== e.pc)     begin mismatched++; $display("FAIL demo_pc: got %h required %h", pc, e.pc); end
        if (cyc != e.cycles) begin mismatched++; $display("FAIL demo_cycles: got %0d required %0d", cyc, e.cycles); end
        if (mem[8] !== 8'h0F) begin mismatched++; $display("FAIL demo_mem8: got %h required 0f", mem[8]); end
        if (store_q.size() != 0) begin mismatched++; $display("FAIL demo_store_missing: %0d pending stores, required 0", store_q.size()); end
    endtask

    task automatic test_add_carry();
        exp_t e;
        int cyc;
        begin_test(8'h00);
        mem[0] = 8'h40; mem[1] = 8'd200; mem[2] = 8'h60; mem[3] = 8'd100;
        mem[4] = 8'h00; mem[5] = 8'hE0;
        e = '{a: 8'h2C, b: 8'h64, c: 1'b1, pc: 8'h06, cycles: 10};
        exp_q.push_back(e);
        release_reset();
        run_program(cyc);
        e = exp_q.pop_front();
        compared += 5;
        if (acc_a !== e.a)   begin mismatched++; $display("FAIL add_a: got %h required %h", acc_a, e.a); end
        if (acc_b !== e.b)   begin mismatched++; $display("FAIL add_b: got %h required %h", acc_b, e.b); end
        if (carry !== e.c)   begin mismatched++; $display("FAIL add_carry: got %b required %b", carry, e.c); end
        if (pc !== e.pc)     begin mismatched++; $display("FAIL add_pc: got %h required %h", pc, e.pc); end
        if (cyc != e.cycles) begin mismatched++; $display("FAIL add_cycles: got %0d required %0d", cyc, e.cycles); end
    endtask

    task automatic test_nop_halt();
        exp_t e;
        int cyc;
        begin_test(8'h00);
        mem[0] = 8'h20; mem[1] = 8'hE0;
        e = '{a: 8'h00, b: 8'h00, c: 1'b0, pc: 8'h02, cycles: 4};
        exp_q.push_back(e);
        release_reset();
        run_program(cyc);
        e = exp_q.pop_front();
        compared += 4;
        if (acc_a !== e.a || acc_b !== e.b) begin mismatched++; $display("FAIL nop_ab: got %h/%h required %h/%h", acc_a, acc_b, e.a, e.b); end
        if (pc !== e.pc)     begin mismatched++; $display("FAIL nop_pc: got %h required %h", pc, e.pc); end
        if (cyc != e.cycles) begin mismatched++; $display("FAIL nop_cycles: got %0d required %0d", cyc, e.cycles); end
        if (busy !== 1'b0)   begin mismatched++; $display("FAIL nop_busy: got %b required 0", busy); end
        // start must not restart a halted machine
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        compared += 2;
        if (halted !== 1'b1) begin mismatched++; $display("FAIL halted_start: halted=%b required 1", halted); end
        if (pc !== 8'h02)    begin mismatched++; $display("FAIL halted_pc: got %h required 02", pc); end
    endtask

    task automatic test_pc_wrap();
        exp_t e;
        store_t s;
        int cyc;
        // NOP at 0, LDA #E0, STR @01 patches 0x01 into HALT, NOPs up to an LDA at 0xFF whose operand wraps to 0x00.
        begin_test(8'h20);
        mem[0] = 8'h33; mem[1] = 8'h40; mem[2] = 8'hE0; mem[3] = 8'h80; mem[4] = 8'h01;
        mem[255] = 8'h40;
        e = '{a: 8'h33, b: 8'h00, c: 1'b0, pc: 8'h02, cycles: 2 + 3 + 3 + 250 * 2 + 3 + 2};
        exp_q.push_back(e);
        s = '{addr: 8'h01, data: 8'hE0};
        store_q.push_back(s);
        release_reset();
        run_program(cyc);
        e = exp_q.pop_front();
        compared += 5;
        if (acc_a !== e.a)   begin mismatched++; $display("FAIL wrap_a: got %h required %h", acc_a, e.a); end
        if (acc_b !== e.b || carry !== e.c) begin mismatched++; $display("FAIL wrap_b_carry: got %h/%b required %h/%b", acc_b, carry, e.b, e.c); end
        if (pc !== e.pc)     begin mismatched++; $display("FAIL wrap_pc: got %h required %h", pc, e.pc); end
        if (cyc != e.cycles) begin mismatched++; $display("FAIL wrap_cycles: got %0d required %0d", cyc, e.cycles); end
        if (store_q.size() != 0) begin mismatched++; $display("FAIL wrap_store_missing: %0d pending stores, required 0", store_q.size()); end
    endtask

    task automatic test_reset_mid_store();
        store_t s;
        int waited;
        begin_test(8'h00);
        mem[0] = 8'h40; mem[1] = 8'h0A; mem[2] = 8'h60; mem[3] = 8'h05;
        mem[4] = 8'h00; mem[5] = 8'h80; mem[6] = 8'h08; mem[7] = 8'hE0;
        s = '{addr: 8'h08, data: 8'h0F};
        store_q.push_back(s);
        release_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.mem_write !== 1'b1 && waited < 50);
        compared++;
        if (bus.mem_write !== 1'b1) begin mismatched++; $display("FAIL abort_no_store: mem_write never rose within %0d cycles", waited); end
        #2 reset = 1'b0;
        #1;
        compared += 5;
        if (bus.mem_write !== 1'b0) begin mismatched++; $display("FAIL abort_write: got %b required 0", bus.mem_write); end
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin mismatched++; $display("FAIL abort_bus: got %h required 0000", {bus.mem_addr, bus.mem_wdata}); end
        if ({pc, acc_a, acc_b} !== 24'h000000) begin mismatched++; $display("FAIL abort_regs: got %h required 000000", {pc, acc_a, acc_b}); end
        if ({carry, busy, halted} !== 3'b000) begin mismatched++; $display("FAIL abort_flags: got %b required 000", {carry, busy, halted}); end
        if (store_q.size() != 0) begin mismatched++; $display("FAIL abort_store_seen: %0d pending stores, required 0", store_q.size()); end
        @(posedge clk);
        #1;
        compared++;
        if (mem[8] !== 8'h00) begin mismatched++; $display("FAIL abort_mem8: got %h required 00", mem[8]); end
        release_reset();
    endtask

`ifdef CPU_SEQUENCER_STEP_EN
    task automatic test_step();
        begin_test(8'h20);
        mem[0] = 8'h40; mem[1] = 8'h5A; mem[2] = 8'h60; mem[3] = 8'h77;
        step = 1'b0;
        release_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        compared += 2;
        if (pc !== 8'h00 || bus.mem_addr !== 8'h00) begin mismatched++; $display("FAIL step_hold_pc: pc=%h addr=%h required 00/00", pc, bus.mem_addr); end
        if (busy !== 1'b1) begin mismatched++; $display("FAIL step_hold_busy: got %b required 1", busy); end
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        compared += 3;
        if (acc_a !== 8'h5A) begin mismatched++; $display("FAIL step_a: got %h required 5a", acc_a); end
        if (acc_b !== 8'h00) begin mismatched++; $display("FAIL step_b: got %h required 00", acc_b); end
        if (pc !== 8'h02)    begin mismatched++; $display("FAIL step_pc: got %h required 02", pc); end
        step = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_demo();
        test_add_carry();
        test_nop_halt();
        test_pc_wrap();
        test_reset_mid_store();
`ifdef CPU_SEQUENCER_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
